// File: rtl/cntr_pkt_pkg.sv
// Shared types and sizing helpers for the counter sample packetizer.
//   state_t    : packet FSM states
//   pkt_hdr_t  : per-packet sideband captured when a packet is committed
//   *_width()  : derived widths, usable from any parameterization
package cntr_pkt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] ts;
        logic [15:0] len;   // items in this packet
        logic        eob;
    } pkt_hdr_t;

    function automatic int bytes_per_item(input int item_w);
        return item_w / 8;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int beat_width(input int spp);
        return $clog2(spp) + 1;
    endfunction

    localparam int DATA_W_DEF     = 8;
    localparam int ITEM_W_DEF     = 32;
    localparam int SPP_DEF        = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam int BYTES_PER_ITEM = bytes_per_item(ITEM_W_DEF);
    localparam int CNT_W          = cnt_width(FIFO_DEPTH_DEF);
    localparam int BEAT_W         = beat_width(SPP_DEF);

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
//   clk_i, rst_i : clock, async active-high reset (pointers/count only)
//   push_i/data_i: write request; taken when not full, or when full with a
//                  simultaneous pop
//   pop_i        : consume head entry (ignored when empty)
//   data_o       : head entry, valid whenever count_o != 0
//   count_o      : entries held, 0..DEPTH
//   full_o       : count_o == DEPTH
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_o != '0);
    // Full + pop frees the head slot in the same edge, so the write fits.
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is registered; read is a plain index so the head is visible
    // without a request (show-ahead).
    assign data_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/cntr_sample_packetizer.sv
// Buffers a strobed sample stream and emits fixed-size AXI-Stream packets
// with CHDR-style sideband (timestamp, has_time, byte length, EOB).
//   clk_i, rst_i          : clock, async active-high reset
//   enable_i              : stream enable; falling edge requests a flush/EOB
//   sample_i/sample_vld_i : sample input, captured only while enabled
//   m_axis_*              : packet stream, NIPC=1, sideband held per packet
//   overflow_o            : sticky, a sample was dropped on a full buffer
//   pkt_cnt_o             : completed packets, wraps
module cntr_sample_packetizer
    import cntr_pkt_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ITEM_W     = ITEM_W_DEF,
    parameter int SPP        = SPP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_vld_i,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [63:0]       m_axis_ttimestamp,
    output logic              m_axis_thas_time,
    output logic [15:0]       m_axis_tlength,
    output logic              m_axis_teob,
    output logic              overflow_o,
    output logic [15:0]       pkt_cnt_o
);

    localparam int BPI   = bytes_per_item(ITEM_W);
    localparam int CW    = cnt_width(FIFO_DEPTH);
    localparam int BW    = beat_width(SPP);

    state_t          state, state_nxt;
    pkt_hdr_t        hdr;
    logic [BW-1:0]   beat;
    logic [63:0]     ts_cnt;
    logic            en_q, en_fall, en_rise;
    logic            flush_pend, flush_clr;
    logic [CW-1:0]   count;
    logic            full;
    logic [ITEM_W-1:0] fifo_dout;
    logic            push_req, pop, drop;
    logic            start_full, start_flush, start, beat_last;

    assign en_fall  = en_q & ~enable_i;
    assign en_rise  = ~en_q & enable_i;
    assign push_req = enable_i & sample_vld_i;
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign drop     = push_req & full & ~pop;

    sample_fifo #(
        .WIDTH (ITEM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .data_i  (ITEM_W'(sample_i)),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .count_o (count),
        .full_o  (full)
    );

    // A packet is only committed once all its items are already buffered,
    // so tvalid never drops mid-packet.
    assign start_full  = (count >= CW'(SPP));
    assign start_flush = flush_pend && (count != '0);
    assign start       = (state == IDLE) && (start_full || start_flush);
    assign beat_last   = (state == SEND) && (16'(beat) == hdr.len - 16'd1);
    assign flush_clr   = ((state == IDLE) && flush_pend && (count == '0)) ||
                         (pop && beat_last && hdr.eob);

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_full || start_flush) state_nxt = SEND;
            SEND:    if (pop && beat_last)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        m_axis_tvalid     = 1'b0;
        m_axis_tdata      = '0;
        m_axis_tlast      = 1'b0;
        m_axis_ttimestamp = '0;
        m_axis_thas_time  = 1'b0;
        m_axis_tlength    = '0;
        m_axis_teob       = 1'b0;
        if (state == SEND) begin
            m_axis_tvalid     = 1'b1;
            m_axis_tdata      = fifo_dout;
            m_axis_tlast      = beat_last;
            m_axis_ttimestamp = hdr.ts;
            m_axis_thas_time  = 1'b1;
            m_axis_tlength    = 16'(hdr.len * 16'(BPI));
            m_axis_teob       = hdr.eob;
        end
    end

    // Packet header capture and beat tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hdr       <= '0;
            beat      <= '0;
            pkt_cnt_o <= '0;
        end else if (start) begin
            hdr.ts  <= ts_cnt;
            hdr.len <= start_full ? 16'(SPP) : 16'(count);
            // With more than SPP buffered, the flush tail goes in a later packet.
            hdr.eob <= start_full ? (flush_pend && (count == CW'(SPP))) : 1'b1;
            beat    <= '0;
        end else if (pop) begin
            if (beat_last) begin
                beat      <= '0;
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Timebase, enable edge detect, flush request and overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt     <= '0;
            en_q       <= 1'b0;
            flush_pend <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            en_q   <= enable_i;
            // A new flush request outranks retiring the previous one.
            if (en_fall)        flush_pend <= 1'b1;
            else if (flush_clr) flush_pend <= 1'b0;
            // A drop in the re-enable cycle must not be lost.
            if (drop)           overflow_o <= 1'b1;
            else if (en_rise)   overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntr_sample_packetizer.sv
module tb_cntr_sample_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  sample = '0;
    logic        vld = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_thas_time, m_axis_teob;
    logic [63:0] m_axis_ttimestamp;
    logic [15:0] m_axis_tlength, pkt_cnt;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [15:0] len;
        logic        eob;
        logic [63:0] ts;
        logic        ht;
    } beat_t;

    beat_t       beats[$];
    beat_t       prev;
    logic        prev_stall = 1'b0;
    int          stab_err = 0;
    logic [63:0] tb_cyc;

    cntr_sample_packetizer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .sample_i          (sample),
        .sample_vld_i      (vld),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (tready),
        .m_axis_ttimestamp (m_axis_ttimestamp),
        .m_axis_thas_time  (m_axis_thas_time),
        .m_axis_tlength    (m_axis_tlength),
        .m_axis_teob       (m_axis_teob),
        .overflow_o        (overflow),
        .pkt_cnt_o         (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference timebase: cycles since reset release.
    always @(posedge clk or posedge rst)
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 64'd1;

    function automatic beat_t cur_out();
        return {m_axis_tdata, m_axis_tlast, m_axis_tlength, m_axis_teob,
                m_axis_ttimestamp, m_axis_thas_time};
    endfunction

    // Handshake logger and stall-stability watcher.
    always @(negedge clk) begin
        beat_t cur;
        cur = cur_out();
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall && (!m_axis_tvalid || cur != prev)) stab_err++;
            if (m_axis_tvalid && tready) beats.push_back(cur);
            prev_stall = m_axis_tvalid && !tready;
            prev = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sample = first + 8'(i);
            vld = 1'b1;
            tick();
        end
        vld = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && beats.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_stream got vld=%b last=%b data=%h want 0/0/0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        tests++;
        if (m_axis_ttimestamp !== 64'd0 || m_axis_thas_time !== 1'b0 ||
            m_axis_tlength !== 16'd0 || m_axis_teob !== 1'b0) begin
            fails++;
            $display("FAIL reset_sideband got ts=%0d ht=%b len=%0d eob=%b want all 0",
                     m_axis_ttimestamp, m_axis_thas_time, m_axis_tlength, m_axis_teob);
        end
        tests++;
        if (overflow !== 1'b0 || pkt_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_status got ovf=%b pkt_cnt=%0d want 0/0", overflow, pkt_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_packet();
        enable = 1'b1;
        tready = 1'b1;
        beats.delete();
        push_burst(8'h10, 8);
        // 8th sample just pushed: count visible now, tvalid one cycle later.
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL t1_latency_early got tvalid=%b want 0", m_axis_tvalid);
        end
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h10) begin
            fails++;
            $display("FAIL t1_first_beat got vld=%b data=%h want 1/00000010",
                     m_axis_tvalid, m_axis_tdata);
        end
        wait_beats(8, 50);
        tests++;
        if (beats.size() != 8) begin
            fails++;
            $display("FAIL t1_beat_count got %0d want 8", beats.size());
        end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            tests++;
            if (beats[i].data !== 32'h10 + 32'(i) || beats[i].last !== (i == 7) ||
                beats[i].len !== 16'd32 || beats[i].eob !== 1'b0 || beats[i].ht !== 1'b1) begin
                fails++;
                $display("FAIL t1_beat%0d got data=%h last=%b len=%0d eob=%b ht=%b want data=%h last=%b len=32 eob=0 ht=1",
                         i, beats[i].data, beats[i].last, beats[i].len, beats[i].eob, beats[i].ht,
                         32'h10 + 32'(i), (i == 7));
            end
        end
        tests++;
        if (pkt_cnt !== 16'd1 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL t1_done got pkt_cnt=%0d vld=%b want 1/0", pkt_cnt, m_axis_tvalid);
        end
    endtask

    task automatic test_flush();
        beats.delete();
        push_burst(8'h00, 11);
        enable = 1'b0;
        tick();
        wait_beats(11, 100);
        tests++;
        if (beats.size() != 11) begin
            fails++;
            $display("FAIL t2_beat_count got %0d want 11", beats.size());
        end
        for (int i = 0; i < 11 && i < beats.size(); i++) begin
            logic [15:0] el;
            logic        ee, elast;
            el    = (i < 8) ? 16'd32 : 16'd12;
            ee    = (i >= 8);
            elast = (i == 7) || (i == 10);
            tests++;
            if (beats[i].data !== 32'(i) || beats[i].last !== elast ||
                beats[i].len !== el || beats[i].eob !== ee) begin
                fails++;
                $display("FAIL t2_beat%0d got data=%h last=%b len=%0d eob=%b want data=%h last=%b len=%0d eob=%b",
                         i, beats[i].data, beats[i].last, beats[i].len, beats[i].eob,
                         32'(i), elast, el, ee);
            end
        end
        repeat (5) tick();
        tests++;
        if (beats.size() != 11 || dut.flush_pend !== 1'b0 || pkt_cnt !== 16'd3) begin
            fails++;
            $display("FAIL t2_after got beats=%0d flush_pend=%b pkt_cnt=%0d want 11/0/3",
                     beats.size(), dut.flush_pend, pkt_cnt);
        end
    endtask

    task automatic test_stall();
        beat_t       snap;
        logic [63:0] ts_exp;
        int          hold_bad;
        hold_bad = 0;
        enable = 1'b1;
        tready = 1'b1;
        beats.delete();
        stab_err = 0;
        push_burst(8'h20, 8);
        tick();
        // Timestamp is the counter value registered at the IDLE->SEND edge.
        ts_exp = tb_cyc - 64'd1;
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_ttimestamp !== ts_exp) begin
            fails++;
            $display("FAIL t3_entry_ts got vld=%b ts=%0d want 1/%0d",
                     m_axis_tvalid, m_axis_ttimestamp, ts_exp);
        end
        wait_beats(3, 50);
        tready = 1'b0;
        snap = cur_out();
        tests++;
        if (snap.data !== 32'h23 || snap.last !== 1'b0) begin
            fails++;
            $display("FAIL t3_stall_beat got data=%h last=%b want 00000023/0", snap.data, snap.last);
        end
        repeat (5) begin
            tick();
            if (m_axis_tvalid !== 1'b1 || cur_out() != snap) hold_bad++;
        end
        tests++;
        if (hold_bad != 0) begin
            fails++;
            $display("FAIL t3_hold got %0d changed cycles want 0", hold_bad);
        end
        tready = 1'b1;
        wait_beats(8, 50);
        tests++;
        if (beats.size() != 8) begin
            fails++;
            $display("FAIL t3_beat_count got %0d want 8", beats.size());
        end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            tests++;
            if (beats[i].data !== 32'h20 + 32'(i) || beats[i].last !== (i == 7) ||
                beats[i].ts !== ts_exp) begin
                fails++;
                $display("FAIL t3_beat%0d got data=%h last=%b ts=%0d want data=%h last=%b ts=%0d",
                         i, beats[i].data, beats[i].last, beats[i].ts,
                         32'h20 + 32'(i), (i == 7), ts_exp);
            end
        end
        tests++;
        if (stab_err != 0 || pkt_cnt !== 16'd4) begin
            fails++;
            $display("FAIL t3_done got stab_err=%0d pkt_cnt=%0d want 0/4", stab_err, pkt_cnt);
        end
    endtask

    task automatic test_overflow();
        tready = 1'b0;
        beats.delete();
        stab_err = 0;
        push_burst(8'h30, 16);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL t4_no_ovf_at_16 got %b want 0", overflow);
        end
        push_burst(8'h40, 1);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL t4_ovf_at_17 got %b want 1", overflow);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL t4_ovf_clear got %b want 0", overflow);
        end
        tready = 1'b1;
        wait_beats(16, 100);
        repeat (5) tick();
        tests++;
        if (beats.size() != 16) begin
            fails++;
            $display("FAIL t4_beat_count got %0d want 16", beats.size());
        end
        // The flush lands with exactly SPP buffered, so the second packet carries EOB.
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            tests++;
            if (beats[i].data !== 32'h30 + 32'(i) || beats[i].last !== (i == 7 || i == 15) ||
                beats[i].len !== 16'd32 || beats[i].eob !== (i >= 8)) begin
                fails++;
                $display("FAIL t4_beat%0d got data=%h last=%b len=%0d eob=%b want data=%h last=%b len=32 eob=%b",
                         i, beats[i].data, beats[i].last, beats[i].len, beats[i].eob,
                         32'h30 + 32'(i), (i == 7 || i == 15), (i >= 8));
            end
        end
        tests++;
        if (stab_err != 0 || pkt_cnt !== 16'd6) begin
            fails++;
            $display("FAIL t4_done got stab_err=%0d pkt_cnt=%0d want 0/6", stab_err, pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tready = 1'b1;
        beats.delete();
        push_burst(8'h50, 8);
        wait_beats(4, 50);
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h54) begin
            fails++;
            $display("FAIL t5_pre_reset got vld=%b data=%h want 1/00000054", m_axis_tvalid, m_axis_tdata);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (m_axis_tvalid !== 1'b0 || pkt_cnt !== 16'd0) begin
            fails++;
            $display("FAIL t5_async_reset got vld=%b pkt_cnt=%0d want 0/0", m_axis_tvalid, pkt_cnt);
        end
        tick(); tick();
        rst = 1'b0;
        beats.delete();
        repeat (20) tick();
        tests++;
        if (beats.size() != 0 || m_axis_tvalid !== 1'b0 || pkt_cnt !== 16'd0) begin
            fails++;
            $display("FAIL t5_residual got beats=%0d vld=%b pkt_cnt=%0d want 0/0/0",
                     beats.size(), m_axis_tvalid, pkt_cnt);
        end
    endtask

    task automatic test_empty_flush();
        enable = 1'b0;
        tick();
        tests++;
        if (dut.flush_pend !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL t6_flush_set got flush_pend=%b vld=%b want 1/0", dut.flush_pend, m_axis_tvalid);
        end
        tick();
        tests++;
        if (dut.flush_pend !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL t6_flush_clear got flush_pend=%b vld=%b want 0/0", dut.flush_pend, m_axis_tvalid);
        end
        enable = 1'b1;
        beats.delete();
        push_burst(8'h60, 8);
        wait_beats(8, 50);
        tests++;
        if (beats.size() != 8) begin
            fails++;
            $display("FAIL t6_beat_count got %0d want 8", beats.size());
        end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            tests++;
            if (beats[i].data !== 32'h60 + 32'(i) || beats[i].last !== (i == 7) ||
                beats[i].len !== 16'd32 || beats[i].eob !== 1'b0) begin
                fails++;
                $display("FAIL t6_beat%0d got data=%h last=%b len=%0d eob=%b want data=%h last=%b len=32 eob=0",
                         i, beats[i].data, beats[i].last, beats[i].len, beats[i].eob,
                         32'h60 + 32'(i), (i == 7));
            end
        end
        tests++;
        if (pkt_cnt !== 16'd1) begin
            fails++;
            $display("FAIL t6_pkt_cnt got %0d want 1", pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_flush();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_empty_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cntr_sample_packetizer.md
Name: cntr_sample_packetizer

Overview:
- Upstream feeder for the axis_data_to_chdr stage. Consumes the 8-bit cntr_o stream from up_down_counter (or any DATA_W sample source) qualified by a valid strobe.
- Buffers samples in a small FIFO and emits fixed-size AXI-Stream packets with sideband: timestamp, has_time, byte length, EOB.
- The output connects directly to the s_axis_* inputs of axis_data_to_chdr, with NIPC=1.

Parameters:
- DATA_W, 8: input sample width; must satisfy DATA_W <= ITEM_W.
- ITEM_W, 32: output item width; multiple of 8.
- SPP, 8: items per full packet; must satisfy 1 <= SPP <= FIFO_DEPTH.
- FIFO_DEPTH, 16: sample buffer depth; power of 2, at least 2.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  stream enable; a 1->0 transition requests a flush/EOB.
- sample_i  in  DATA_W  sample value.
- sample_vld_i  in  1  sample strobe; the sample is captured only when enable_i=1.
- m_axis_tdata  out  ITEM_W  zero-extended sample.
- m_axis_tlast  out  1  last item of the packet.
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- m_axis_ttimestamp  out  64  packet timestamp.
- m_axis_thas_time  out  1  constant 1 during a packet.
- m_axis_tlength  out  16  packet length in bytes; constant for the whole packet.
- m_axis_teob  out  1  end-of-burst flag; constant for the whole packet.
- overflow_o  out  1  sticky flag: a sample was dropped.
- pkt_cnt_o  out  16  completed packet count; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately): FIFO emptied, FSM to IDLE, all outputs 0, timestamp counter 0, flush_pend 0, previous-enable register 0.
- Timestamp counter: 64-bit, increments every cycle, wraps.
- Push:
  - Occurs when enable_i & sample_vld_i.
  - Data written is sample_i zero-extended to ITEM_W.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and overflow_o is set.
  - A push and a pop in the same cycle while full is accepted; count is unchanged.
- overflow_o: cleared only on reset or on a 0->1 transition of enable_i.
- flush_pend: set on a 1->0 transition of enable_i (registered edge detect). Set has priority over clear in the same cycle.
- FSM states: IDLE, SEND.
  - IDLE, count >= SPP: latch len = SPP, eob = flush_pend & (count == SPP), ts = counter; go to SEND.
  - IDLE, count < SPP, flush_pend & count > 0: latch len = count, eob = 1, ts = counter; go to SEND.
  - IDLE, flush_pend & count == 0: clear flush_pend; no packet is emitted.
  - SEND: m_axis_tvalid = 1. Beat counter runs 0..len-1. m_axis_tlast = 1 when beat == len-1.
  - On each tvalid & tready: pop one item and advance the beat.
  - On the tlast handshake: pkt_cnt_o++. If eob, clear flush_pend. Return to IDLE (one bubble cycle between packets).
- Sideband during SEND:
  - m_axis_tlength = len * ITEM_W/8.
  - m_axis_teob = eob.
  - m_axis_ttimestamp = ts.
  - m_axis_thas_time = 1.
  - All sideband outputs are 0 in IDLE.
- Stability: while tvalid & !tready, tdata, tlast and all sideband outputs must hold.
- Packet reservation: items for a packet are already in the FIFO when SEND is entered, so tvalid never drops mid-packet.
- FIFO is show-ahead with registered storage.
- Latency: the SPP-th sample is pushed at cycle N; count is visible at N+1; SEND is entered and the first tvalid appears at N+2.
- Data is never reordered. Pushes continue during SEND into free space.

Decomposition:
- Package cntr_pkt_pkg:
  - state enum {IDLE, SEND}
  - BYTES_PER_ITEM = ITEM_W/8
  - CNT_W = $clog2(FIFO_DEPTH) + 1
  - BEAT_W = $clog2(SPP) + 1
- Sub-module sample_fifo: a single-clock show-ahead FIFO with count output. It can be reused elsewhere.

Test Plan:
1. enable_i=1; 8 consecutive samples 0x10..0x17; tready=1 -> one packet with tdata 0x00000010..0x00000017, tlast on beat 8, tlength=32, teob=0, has_time=1, pkt_cnt_o=1.
2. 11 samples 0x00..0x0A, then enable_i 1->0 -> packet A: 8 beats, tlength=32, teob=0. Packet B: 0x08..0x0A, tlength=12, teob=1. flush_pend is then clear.
3. Full packet with tready=0 for 5 cycles at beat 3 -> tdata, tlast and sideband held stable; all 8 items delivered in order; packet timestamp equals the counter value at SEND entry.
4. tready=0; push 17 samples -> 16 buffered, 17th dropped, overflow_o=1. Toggle enable_i 0->1 -> overflow_o=0. Packet data and order are unaffected.
5. Assert rst_i at beat 4 of a packet -> tvalid=0 in the same cycle. After release, no residual beats appear and pkt_cnt_o=0.
6. enable_i 1->0 with an empty FIFO -> no packet emitted, flush_pend clears within 1 cycle. A following 8-sample burst produces a normal teob=0 packet.
